mul_seq: RTL and testbench

- Iterative radix-2 shift-add multiply sequencer for MUL/MLA in the multicycle ARM core.
- Sits beside the ALU and is started by the main control FSM from its execute state.
- The main FSM holds in a wait state while busy=1, then writes result back on done.
- Result is the low WIDTH bits of srca*srcb (+acc for MLA), plus N/Z flags for the S-bit.

---
 rtl/mul_seq_pkg.sv | 32 +++
 rtl/mul_seq_dp.sv | 79 +++++++
 rtl/mul_seq.sv | 151 +++++++++++++++
 tb/tb_mul_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the iterative MUL/MLA sequencer:
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - default operand width
//   - bit positions of the N and Z flags in the 2-bit flags output
//   - helper deciding whether the current RUN cycle is the last one
// -----------------------------------------------------------------------------
package mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Positions inside flags[1:0] = {N, Z}
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A RUN cycle is the last one when the bit counter is exhausted, or, with
    // early termination enabled, when no set multiplier bits remain after the
    // shift (the remaining iterations could only add zero).
    function automatic logic is_last_step(input logic cnt_zero,
                                          input logic mplier_rest_zero,
                                          input logic early_term_en);
        return cnt_zero | (early_term_en & mplier_rest_zero);
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// -----------------------------------------------------------------------------
// mul_seq_dp
// Shift-add datapath of the multiply sequencer: multiplicand, multiplier and
// partial-sum registers plus the adder.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   load              - capture srca/srcb and the initial sum (acc or 0)
//   step              - perform one radix-2 iteration
//   srca, srcb, acc   - operands (multiplicand, multiplier, accumulate value)
//   accumulate        - 1: initial sum is acc (MLA), 0: initial sum is 0 (MUL)
//   sum_step          - partial sum after the current iteration (combinational)
//   mplier_rest_zero  - multiplier is zero after the current shift
// -----------------------------------------------------------------------------
module mul_seq_dp
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] acc,
    input  logic             accumulate,
    output logic [WIDTH-1:0] sum_step,
    output logic             mplier_rest_zero
);

    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic [WIDTH-1:0] addend_s;
    logic [WIDTH-1:0] sum_step_s;
    logic [WIDTH-1:0] mplier_shift_s;

    // Next-state of the operand registers: load, iterate or hold.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_d    = sum_q;

        addend_s       = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
        // Carry out of the top bit is dropped: only the low WIDTH bits matter.
        sum_step_s     = sum_q + addend_s;
        mplier_shift_s = {1'b0, mplier_q[WIDTH-1:1]};

        if (load) begin
            mcand_d  = srca;
            mplier_d = srcb;
            sum_d    = accumulate ? acc : {WIDTH{1'b0}};
        end else if (step) begin
            sum_d    = sum_step_s;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = mplier_shift_s;
        end else begin
            sum_d    = sum_q;
        end
    end

    // Operand and partial-sum registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            sum_q    <= {WIDTH{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sum_q    <= sum_d;
        end
    end

    assign sum_step         = sum_step_s;
    assign mplier_rest_zero = (mplier_shift_s == {WIDTH{1'b0}});

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Iterative radix-2 shift-add multiply sequencer for MUL/MLA. A start in IDLE
// or DONE latches the operands; WIDTH RUN cycles later (or earlier with early
// termination) the low WIDTH bits of srca*srcb (+acc) appear on result with
// {N,Z} flags, accompanied by a one-cycle done pulse.
//
// Optional feature macro: MUL_SEQ_EARLY_TERM_EN
//   defined   - leave RUN as soon as the shifted multiplier is zero
//               (at least one RUN cycle is always executed)
//   undefined - always exactly WIDTH RUN cycles
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start       - request a multiply (ignored while busy)
//   srca        - multiplicand (Rm)
//   srcb        - multiplier (Rs)
//   acc         - accumulate operand (Rn), used when accumulate=1
//   accumulate  - 1 = MLA, 0 = MUL
//   busy        - high while in RUN
//   done        - one-cycle pulse when result/flags become valid
//   result      - product, held until the next operation completes
//   flags       - {N,Z} of result
// -----------------------------------------------------------------------------
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] acc,
    input  logic             accumulate,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags
);

`ifdef MUL_SEQ_EARLY_TERM_EN
    localparam logic EARLY_TERM_EN = 1'b1;
`else
    localparam logic EARLY_TERM_EN = 1'b0;
`endif

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_e           state_q,  state_d;
    logic [CNTW-1:0]  cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       flags_q,  flags_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic [WIDTH-1:0] sum_step_s;
    logic             mplier_rest_zero_s;

    mul_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk              (clk),
        .reset            (reset),
        .load             (load_s),
        .step             (step_s),
        .srca             (srca),
        .srcb             (srcb),
        .acc              (acc),
        .accumulate       (accumulate),
        .sum_step         (sum_step_s),
        .mplier_rest_zero (mplier_rest_zero_s)
    );

    // Next-state, counter, datapath enables and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        load_s   = 1'b0;
        step_s   = 1'b0;
        last_s   = is_last_step((cnt_q == {CNTW{1'b0}}), mplier_rest_zero_s,
                                EARLY_TERM_EN);

        case (state_q)
            // DONE accepts a start exactly like IDLE for back-to-back issue.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    cnt_d   = CNT_LAST;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    // Result and flags are taken from the final partial sum
                    // so they are valid in the same cycle as done.
                    state_d          = ST_DONE;
                    done_d           = 1'b1;
                    result_d         = sum_step_s;
                    flags_d[FLAG_N]  = sum_step_s[WIDTH-1];
                    flags_d[FLAG_Z]  = (sum_step_s == {WIDTH{1'b0}});
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNTW{1'b0}};
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Self-checking bench for mul_seq (WIDTH=32). Expected products come from
// plain 64-bit arithmetic truncated to 32 bits; expected latency comes from
// the number of significant multiplier bits when early termination is built in.
// -----------------------------------------------------------------------------
module tb_mul_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [W-1:0] acc;
    logic         accumulate;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   flags;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] last_result;

    mul_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .srca       (srca),
        .srcb       (srcb),
        .acc        (acc),
        .accumulate (accumulate),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: low W bits of a*b (+c).
    function automatic logic [W-1:0] model_result(input logic [W-1:0] a,
                                                  input logic [W-1:0] b,
                                                  input logic [W-1:0] c,
                                                  input logic m);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (m) p = p + {32'd0, c};
        return p[W-1:0];
    endfunction

    function automatic logic [1:0] model_flags(input logic [W-1:0] r);
        return {r[W-1], (r == '0)};
    endfunction

    // Number of RUN cycles (clock edges from the start edge to done).
    function automatic int model_cycles(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
        int          n;
        logic [W-1:0] v;
        n = 0;
        v = b;
        while (v != '0) begin
            v = v >> 1;
            n++;
        end
        return (n == 0) ? 1 : n;
`else
        return W;
`endif
    endfunction

    // Called at a negedge: present operands with start and let the edge take them.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic m);
        srca = a; srcb = b; acc = c; accumulate = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Inputs may change freely once the operation is accepted.
        srca = $urandom; srcb = $urandom; acc = $urandom;
        accumulate = 1'($urandom_range(0, 1));
    endtask

    // Waits for done, checking busy/stale result on the way; ends at the
    // negedge of the done cycle.
    task automatic wait_done(input string tag, input logic [W-1:0] exp_res,
                             input int exp_cyc, input logic inject);
        int   cycles;
        logic got;
        cycles = 0;
        got    = 1'b0;
        while (cycles < 100 && !got) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                check({tag, "_stale"}, 64'(result), 64'(last_result));
                if (inject && cycles == 4) begin
                    srca = $urandom; srcb = $urandom; start = 1'b1;
                end
                if (inject && cycles == 5) start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_timeout"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(cycles), 64'(exp_cyc));
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_flags"}, 64'(flags), 64'(model_flags(exp_res)));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        last_result = exp_res;
    endtask

    task automatic check_drop(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, 64'(result), 64'(last_result));
    endtask

    task automatic op(input string tag, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic m, input logic inject);
        launch(a, b, c, m);
        wait_done(tag, model_result(a, b, c, m), model_cycles(b), inject);
        check_drop(tag);
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        logic         m;

        reset = 1'b1; start = 1'b0; srca = '0; srcb = '0; acc = '0;
        accumulate = 1'b0; last_result = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 1'b0);
        op("mla_neg", 32'hFFFF_FFFF, 32'd3, 32'd3, 1'b1, 1'b0);
        op("ovf_zero", 32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b0);
        op("neg_res", 32'h4000_0000, 32'd2, 32'd0, 1'b0, 1'b0);
        op("ignore_start", 32'h0000_1234, 32'h8000_5678, 32'd0, 1'b0, 1'b1);

        // Back-to-back: second start presented in the DONE cycle.
        launch(32'd1000, 32'hC000_0003, 32'd5, 1'b1);
        wait_done("b2b_first", model_result(32'd1000, 32'hC000_0003, 32'd5, 1'b1),
                  model_cycles(32'hC000_0003), 1'b0);
        launch(32'hDEAD_BEEF, 32'h8765_4321, 32'd0, 1'b0);
        wait_done("b2b_second", model_result(32'hDEAD_BEEF, 32'h8765_4321, 32'd0, 1'b0),
                  model_cycles(32'h8765_4321), 1'b0);
        check_drop("b2b_second");

        op("srcb_zero", 32'd123, 32'd0, 32'd77, 1'b1, 1'b0);
        op("nine_x_five", 32'd9, 32'd5, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an operation.
        launch(32'h1111_1111, 32'hF000_000F, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_result = '0;
        @(negedge clk);
        op("after_rst", 32'd12345, 32'd6789, 32'd1, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 255));
            c = $urandom;
            m = 1'($urandom_range(0, 1));
            op("rand", a, b, c, m, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
